// File: rtl/ifq_fetch_queue.sv
// Instruction fetch queue: issues one instruction read per cycle and buffers
// {pc+4, instruction} pairs in a show-ahead FIFO for the dispatcher.
module ifq_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_jmp_br_addr,
    input  logic        i_jmp_valid,
    input  logic        i_rd_en,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_rd_en,
    input  logic [31:0] i_mem_data,
    input  logic        i_mem_valid,
    output logic [31:0] o_pc_plus_4,
    output logic [31:0] o_instruction,
    output logic        o_empty
);

    localparam int            AW      = $clog2(DEPTH);
    localparam int            CW      = AW + 1;
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);

    logic [31:0]   pc;
    logic [31:0]   req_pc;
    logic          pending;
    logic          drop;
    logic [CW-1:0] count;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [31:0]   pc4_mem   [DEPTH];
    logic [31:0]   instr_mem [DEPTH];

    logic [CW:0]   occupancy;
    logic          empty;
    logic          issue;
    logic          push;
    logic          pop;

    // An outstanding request reserves its slot so a response can never overflow.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, pending};
    assign empty     = (count == '0);
    assign issue     = !i_rst && !i_jmp_valid && (occupancy < DEPTH_W);
    assign push      = !i_rst && !i_jmp_valid && i_mem_valid && pending && !drop;
    assign pop       = !i_rst && !i_jmp_valid && i_rd_en && !empty;

    assign o_mem_addr    = pc;
    assign o_mem_rd_en   = issue;
    assign o_empty       = empty;
    assign o_pc_plus_4   = empty ? '0 : pc4_mem[rd_ptr];
    assign o_instruction = empty ? '0 : instr_mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc      <= RESET_PC;
            req_pc  <= RESET_PC;
            pending <= 1'b0;
            drop    <= 1'b0;
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
        end else if (i_jmp_valid) begin
            pc      <= i_jmp_br_addr;
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            // A response still to come belongs to the old path and must be discarded.
            pending <= pending && !i_mem_valid;
            drop    <= (drop || pending) && !i_mem_valid;
        end else begin
            if (issue) begin
                pc     <= pc + 32'd4;
                req_pc <= pc;
            end
            pending <= issue || (pending && !i_mem_valid);
            if (i_mem_valid) begin
                drop <= 1'b0;
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // NOTE: the entry storage has no reset; o_empty and the output forcing
    // guarantee a stale slot is never observed.
    always_ff @(posedge i_clk) begin
        if (push) begin
            pc4_mem[wr_ptr]   <= req_pc + 32'd4;
            instr_mem[wr_ptr] <= i_mem_data;
        end
    end

endmodule

// File: tb/tb_ifq_fetch_queue.sv
// Randomized self-checking bench for ifq_fetch_queue against a queue-based
// reference model of the fetch queue behaviour.
module tb_ifq_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        i_clk;
    logic        i_rst;
    logic [31:0] i_jmp_br_addr;
    logic        i_jmp_valid;
    logic        i_rd_en;
    logic [31:0] o_mem_addr;
    logic        o_mem_rd_en;
    logic [31:0] i_mem_data;
    logic        i_mem_valid;
    logic [31:0] o_pc_plus_4;
    logic [31:0] o_instruction;
    logic        o_empty;

    ifq_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_jmp_br_addr (i_jmp_br_addr),
        .i_jmp_valid   (i_jmp_valid),
        .i_rd_en       (i_rd_en),
        .o_mem_addr    (o_mem_addr),
        .o_mem_rd_en   (o_mem_rd_en),
        .i_mem_data    (i_mem_data),
        .i_mem_valid   (i_mem_valid),
        .o_pc_plus_4   (o_pc_plus_4),
        .o_instruction (o_instruction),
        .o_empty       (o_empty)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Reference model: entries as a queue of {pc+4, instr}.
    logic [63:0] m_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_req_pc;
    bit          m_pending;
    bit          m_drop;
    bit          checking = 0;

    // Instruction memory environment: responds one cycle after an observed request.
    logic [31:0] xor_key   = 32'h0;
    bit          resp_due  = 0;
    logic [31:0] resp_addr = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ xor_key;
    endfunction

    task automatic model_step(input bit rst, input bit jmp, input logic [31:0] jaddr,
                              input bit rd, input bit mv, input logic [31:0] mdata,
                              input bit issue);
        if (rst) begin
            m_q.delete();
            m_pc      = RESET_PC;
            m_req_pc  = RESET_PC;
            m_pending = 0;
            m_drop    = 0;
        end else if (jmp) begin
            m_q.delete();
            m_pc      = jaddr;
            m_drop    = (m_drop || m_pending) && !mv;
            m_pending = m_pending && !mv;
        end else begin
            bit do_pop;
            do_pop = rd && (m_q.size() != 0);
            if (do_pop) void'(m_q.pop_front());
            if (mv) begin
                if (m_pending && !m_drop) m_q.push_back({m_req_pc + 32'd4, mdata});
                m_drop = 0;
            end
            if (issue) begin
                m_req_pc  = m_pc;
                m_pc      = m_pc + 32'd4;
                m_pending = 1;
            end else if (mv) begin
                m_pending = 0;
            end
        end
    endtask

    // One clock cycle: drive inputs, compare outputs, advance the model.
    task automatic cycle(input bit rst, input bit jmp, input logic [31:0] jaddr,
                         input bit rd, input bit force_mv);
        bit          exp_issue;
        bit          mv;
        logic [31:0] mdata;
        logic [63:0] head;
        mv            = resp_due || force_mv;
        mdata         = mem_word(resp_addr);
        i_rst         = rst;
        i_jmp_valid   = jmp;
        i_jmp_br_addr = jaddr;
        i_rd_en       = rd;
        i_mem_valid   = mv;
        i_mem_data    = mdata;
        #1;
        exp_issue = !rst && !jmp && (m_q.size() + int'(m_pending) < DEPTH);
        head      = (m_q.size() != 0) ? m_q[0] : 64'h0;
        check("mem_rd_en", {31'h0, o_mem_rd_en}, {31'h0, exp_issue});
        if (checking) begin
            check("empty",       {31'h0, o_empty}, {31'h0, m_q.size() == 0});
            check("mem_addr",    o_mem_addr,    m_pc);
            check("pc_plus_4",   o_pc_plus_4,   head[63:32]);
            check("instruction", o_instruction, head[31:0]);
        end
        model_step(rst, jmp, jaddr, rd, mv, mdata, exp_issue);
        resp_addr = o_mem_addr;
        @(posedge i_clk);
        @(negedge i_clk);
        resp_due = o_mem_rd_en === 1'b1;
        checking = 1;
    endtask

    initial begin
        i_rst = 1'b1; i_jmp_valid = 1'b0; i_jmp_br_addr = '0;
        i_rd_en = 1'b0; i_mem_valid = 1'b0; i_mem_data = '0;

        // Reset, then fill without popping: four requests, then stall.
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 0);
        // Single pop frees one slot for exactly one refill request.
        cycle(0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0);
        // Continuous pop with pointer wrap.
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 1, 0);
        // Redirect while a request is outstanding.
        cycle(0, 1, 32'h0000_0100, 1, 0);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, 0);
        // Pop on empty queue right after a flush.
        cycle(0, 1, 32'h0000_0200, 0, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 0);
        // PC wrap at the top of the address space.
        cycle(0, 1, 32'hFFFF_FFF8, 0, 0);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, 0);
        // Reset with three entries queued and a request pending, then a late response.
        cycle(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0);
        cycle(1, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 0);

        // Randomized traffic with distinct memory contents.
        xor_key = 32'hC3A5_5A3C;
        for (int i = 0; i < 1500; i++) begin
            bit          r_rst;
            bit          r_jmp;
            bit          r_rd;
            logic [31:0] r_addr;
            r_rst  = ($urandom_range(99) < 2);
            r_jmp  = ($urandom_range(99) < 8);
            r_rd   = ($urandom_range(99) < 60);
            r_addr = ($urandom_range(9) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'hFFFF_FFFC);
            cycle(r_rst, r_jmp, r_addr, r_rd, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
